regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-read-port integer register file for the core's decode/writeback path. Next generation of the single-clock register storage.
- Single clock with write-to-read bypass; register 0 can be hardwired to zero.
- Synchronous clear sweep after reset, with a `ready` flag.
- Per-register pending-write scoreboard so decode can detect RAW hazards.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers (power of two, ≥4).
- NRD, 2, number of combinational read ports (1..4).
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes and reservations.
- AW, $clog2(NREGS), derived select width; do not override.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- ready  out  1  high once the clear sweep has completed.
- wen  in  1  writeback enable.
- wsel  in  AW  writeback register index.
- wdata  in  XLEN  writeback data.
- rsel  in  NRD*AW  read indices; port k occupies bits [k*AW +: AW].
- rdata  out  NRD*XLEN  read data per port, same packing.
- rbusy  out  NRD  per-port "pending write" flag.
- rsv_en  in  1  reserve the destination register of an issuing instruction.
- rsv_sel  in  AW  register to reserve.
- busy_vec  out  NREGS  raw scoreboard contents.

Behaviour:
- State machine: RF_CLEAR and RF_READY.
- While rst=1: state=RF_CLEAR, clr_idx=0, scoreboard=0, ready=0.
- Register contents are not touched while rst is held; they are cleared by the sweep.
- RF_CLEAR, after rst falls: each cycle write 0 to reg[clr_idx], then clr_idx++.
  - When reg[NREGS-1] has been written, the next state is RF_READY.
  - ready rises exactly NREGS cycles after the first cycle with rst=0.
- rst reasserted during RF_CLEAR or RF_READY restarts the sweep from index 0.
- While ready=0:
  - wen and rsv_en are ignored.
  - All rdata=0 and all rbusy=0.
  - busy_vec=0.
- Write (RF_READY): if wen and !(ZERO_REG && wsel==0), reg[wsel] <= wdata at posedge.
- Write also clears the scoreboard bit: busy[wsel] <= 0.
- Reserve: if rsv_en and !(ZERO_REG && rsv_sel==0), busy[rsv_sel] <= 1.
- Simultaneous write and reserve to the same index: data is written and busy ends at 1 (the reserve wins).
- Reserve of an already-busy register: busy stays 1 (no counting).
- Read port k is fully combinational:
  - if ZERO_REG && rsel_k==0 → 0;
  - else if wen && wsel==rsel_k (valid write) → wdata (bypass);
  - else reg[rsel_k].
- rbusy[k] = busy[rsel_k] & ~(valid write to rsel_k this cycle), so a same-cycle writeback resolves the hazard.
  - A same-cycle reserve does not show on rbusy until the next cycle.
- busy_vec reflects registered state only (no bypass).
- Bit 0 of busy_vec is always 0 when ZERO_REG=1.
- Index widths are exact, so no out-of-range handling is needed.

Optional Feature:
- Macro: REGFILE_MP_DBG_EN.
- With the macro:
  - Extra ports: dbg_sel (in, AW), dbg_rdata (out, XLEN), wr_count (out, 32).
  - dbg_rdata = reg[dbg_sel] (no bypass, 0 for reg 0 when ZERO_REG).
  - wr_count counts committed writes (writes to reg 0 not counted) and wraps at 2^32.
  - wr_count is cleared by rst.
- Without the macro: these ports and the counter do not exist, and behaviour is otherwise identical.

Decomposition:
- Package regfile_pkg holds:
  - default XLEN constant;
  - rf_state_e enum {RF_CLEAR, RF_READY};
  - localparam RF_CNT_W=32 for the debug counter.
- Sub-module regfile_scoreboard (NREGS, ZERO_REG):
  - owns the busy vector, reserve/clear priority and the rbusy masking;
  - the top keeps storage, the clear FSM and the bypass muxes.

Test Plan:
- Reset with NREGS=32: pulse rst 1 cycle → ready=0 for 32 cycles then 1; all rdata=0; busy_vec=0.
- Bypass: ready, wen=1 wsel=5 wdata=0xDEADBEEF, rsel port0=5 in the same cycle → rdata0=0xDEADBEEF combinationally; next cycle without wen still 0xDEADBEEF.
- Reg 0: wen wsel=0 wdata=0x1234 and rsv_en rsv_sel=0 → rdata for rsel=0 is 0, busy_vec[0]=0, wr_count unchanged (DBG build).
- Scoreboard:
  - rsv_en rsv_sel=7 → next cycle busy_vec[7]=1 and rbusy=1 on a port reading 7;
  - later wen wsel=7 → rbusy=0 that same cycle and busy_vec[7]=0 the next.
- Collision: same cycle wen wsel=9 wdata=0x55 and rsv_en rsv_sel=9 → next cycle reg9=0x55 and busy_vec[9]=1.
- Mid-sweep reset: assert rst at sweep index 10 → ready stays 0, sweep restarts, ready rises 32 cycles after rst falls; writes issued during the sweep have no effect.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and state type for the multi-port register file.
package regfile_pkg;

    localparam int RF_XLEN  = 32;
    localparam int RF_CNT_W = 32;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by reserve, cleared by writeback.
module regfile_scoreboard #(
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1,
    parameter int NRD      = 2,
    parameter int AW       = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ready,
    input  logic              i_wr_vld,
    input  logic [AW-1:0]     i_wsel,
    input  logic              i_rsv_en,
    input  logic [AW-1:0]     i_rsv_sel,
    input  logic [NRD*AW-1:0] i_rsel,
    output logic [NRD-1:0]    o_rbusy,
    output logic [NREGS-1:0]  o_busy_vec
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;
    logic             w_rsv_vld;

    assign w_rsv_vld = i_ready & i_rsv_en & ~((ZERO_REG != 0) && (i_rsv_sel == '0));

    // Reserve is applied after the clear so a same-cycle collision leaves the bit set.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_wr_vld)
            w_busy_nxt[i_wsel] = 1'b0;
        if (w_rsv_vld)
            w_busy_nxt[i_rsv_sel] = 1'b1;
        if (ZERO_REG != 0)
            w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_busy <= '0;
        else
            r_busy <= w_busy_nxt;
    end

    assign o_busy_vec = i_ready ? r_busy : '0;

    for (genvar k = 0; k < NRD; k++) begin : g_rbusy
        logic [AW-1:0] w_sel;
        assign w_sel      = i_rsel[k*AW +: AW];
        assign o_rbusy[k] = i_ready & r_busy[w_sel] & ~(i_wr_vld && (i_wsel == w_sel));
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write bypass, post-reset clear sweep and RAW scoreboard.
// Optional debug read port and write counter enabled by REGFILE_MP_DBG_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = RF_XLEN,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ready,
    input  logic                wen,
    input  logic [AW-1:0]       wsel,
    input  logic [XLEN-1:0]     wdata,
    input  logic [NRD*AW-1:0]   rsel,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_sel,
    output logic [NREGS-1:0]    busy_vec
`ifdef REGFILE_MP_DBG_EN
    ,
    input  logic [AW-1:0]       dbg_sel,
    output logic [XLEN-1:0]     dbg_rdata,
    output logic [RF_CNT_W-1:0] wr_count
`endif
);

    rf_state_e       r_state;
    logic [AW-1:0]   r_clr_idx;
    logic            r_ready;
    logic [XLEN-1:0] r_regs [NREGS];
    logic            w_wr_vld;

    assign w_wr_vld = r_ready & wen & ~((ZERO_REG != 0) && (wsel == '0));
    assign ready    = r_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RF_CLEAR;
            r_clr_idx <= '0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                RF_CLEAR: begin
                    r_clr_idx <= r_clr_idx + AW'(1);
                    if (r_clr_idx == AW'(NREGS - 1)) begin
                        r_state <= RF_READY;
                        r_ready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage has no reset; the sweep zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == RF_CLEAR)
                r_regs[r_clr_idx] <= '0;
            else if (w_wr_vld)
                r_regs[wsel] <= wdata;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] w_sel;
        assign w_sel = rsel[k*AW +: AW];
        assign rdata[k*XLEN +: XLEN] =
            !r_ready                             ? '0    :
            ((ZERO_REG != 0) && (w_sel == '0))   ? '0    :
            (w_wr_vld && (wsel == w_sel))        ? wdata :
                                                   r_regs[w_sel];
    end

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG),
        .NRD      (NRD),
        .AW       (AW)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .i_ready    (r_ready),
        .i_wr_vld   (w_wr_vld),
        .i_wsel     (wsel),
        .i_rsv_en   (rsv_en),
        .i_rsv_sel  (rsv_sel),
        .i_rsel     (rsel),
        .o_rbusy    (rbusy),
        .o_busy_vec (busy_vec)
    );

`ifdef REGFILE_MP_DBG_EN
    logic [RF_CNT_W-1:0] r_wr_count;

    always_ff @(posedge clk) begin
        if (rst)
            r_wr_count <= '0;
        else if (w_wr_vld)
            r_wr_count <= r_wr_count + RF_CNT_W'(1);
    end

    assign wr_count  = r_wr_count;
    assign dbg_rdata = ((ZERO_REG != 0) && (dbg_sel == '0)) ? '0 : r_regs[dbg_sel];
`endif

endmodule
